// File: rtl/single_port_ram_arb_if.sv
// Bus bundle between two requesters, the arbiter and a single-port RAM.
//   master : environment side (requesters drive req/we/lock/addr/wdata,
//            RAM drives ram_rdata)
//   slave  : arbiter side (drives gnt, rvalid, rdata and the RAM command)
interface single_port_ram_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic              lock0;
    logic              lock1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/single_port_ram_arb.sv
// Two-requester arbiter in front of a single-port RAM with one-cycle read
// latency. Round-robin arbitration with optional lock (ownership kept across
// accesses). Grants are combinational; the RAM command is registered one
// cycle after the grant and read data returns two cycles after the grant.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : single_port_ram_arb_if.slave (requester handshakes, read return,
//          RAM command and RAM read data)
//
// state | meaning
// ------+---------------------------------------------
// RR    | round-robin between requesters, prio picks on contention
// OWN0  | locked to requester 0, requester 1 held off
// OWN1  | locked to requester 1, requester 0 held off
module single_port_ram_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    single_port_ram_arb_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RR   = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              prio_q;      // 0 = requester 0 wins on contention
    logic              prio_d;
    logic              gnt0_c;
    logic              gnt1_c;

    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    // Read return tracking: stage 1 lines up with the RAM command, stage 2
    // with the RAM read data.
    logic              rd_v1_q;
    logic              rd_o1_q;
    logic              rd_v2_q;
    logic              rd_o2_q;

    always_comb begin
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;
        state_d = state_q;
        prio_d  = prio_q;

        if (rst) begin
            case (state_q)
                ST_RR: begin
                    if (bus.req0 && (!bus.req1 || !prio_q)) begin
                        gnt0_c = 1'b1;
                    end else if (bus.req1) begin
                        gnt1_c = 1'b1;
                    end
                end
                ST_OWN0: begin
                    if (bus.req0) begin
                        gnt0_c = 1'b1;
                    end else begin
                        // Owner went away: release the lock.
                        state_d = ST_RR;
                        prio_d  = 1'b1;
                    end
                end
                ST_OWN1: begin
                    if (bus.req1) begin
                        gnt1_c = 1'b1;
                    end else begin
                        state_d = ST_RR;
                        prio_d  = 1'b0;
                    end
                end
                default: state_d = ST_RR;
            endcase

            // Any grant hands priority to the other side; lock decides
            // whether ownership is kept.
            if (gnt0_c) begin
                prio_d  = 1'b1;
                state_d = bus.lock0 ? ST_OWN0 : ST_RR;
            end
            if (gnt1_c) begin
                prio_d  = 1'b0;
                state_d = bus.lock1 ? ST_OWN1 : ST_RR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RR;
            prio_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_v1_q     <= 1'b0;
            rd_o1_q     <= 1'b0;
            rd_v2_q     <= 1'b0;
            rd_o2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            ram_en_q <= gnt0_c | gnt1_c;
            ram_we_q <= (gnt0_c & bus.we0) | (gnt1_c & bus.we1);
            if (gnt0_c) begin
                ram_addr_q  <= bus.addr0;
                ram_wdata_q <= bus.wdata0;
            end else if (gnt1_c) begin
                ram_addr_q  <= bus.addr1;
                ram_wdata_q <= bus.wdata1;
            end
            rd_v1_q <= (gnt0_c & ~bus.we0) | (gnt1_c & ~bus.we1);
            rd_o1_q <= gnt1_c;
            rd_v2_q <= rd_v1_q;
            rd_o2_q <= rd_o1_q;
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.rvalid0   = rd_v2_q & ~rd_o2_q;
    assign bus.rvalid1   = rd_v2_q &  rd_o2_q;
    // Read data goes straight through; rvalidN is the only qualifier.
    assign bus.rdata0    = bus.ram_rdata;
    assign bus.rdata1    = bus.ram_rdata;

endmodule

// File: tb/tb_single_port_ram_arb.sv
module tb_single_port_ram_arb;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk;
    logic rst;
    logic preload;
    int   n_tests = 0;
    int   n_fail  = 0;

    single_port_ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    single_port_ram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM model, one-cycle read latency.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ram_rdata_q;

    always @(posedge clk) begin
        if (preload) begin
            mem[8'h05] <= 16'h1234;
            mem[8'h20] <= 16'hA0A0;
            mem[8'h21] <= 16'hA1A1;
        end else if (bus.ram_en && bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        if (bus.ram_en && !bus.ram_we) begin
            ram_rdata_q <= mem[bus.ram_addr];
        end
    end

    assign bus.ram_rdata = ram_rdata_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.lock0  = 1'b0;
        bus.lock1  = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        idle_in();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        preload = 1'b1;
        idle_in();
        tick();
        preload = 1'b0;

        // Reset state; requests must not be granted while in reset.
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        #1;
        chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
        chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
        idle_in();
        rst = 1'b1;
        tick();

        // Single read of 0x05.
        bus.req0  = 1'b1;
        bus.addr0 = 8'h05;
        #1;
        chk("rd_gnt0", 32'(bus.gnt0), 32'd1);
        chk("rd_gnt1", 32'(bus.gnt1), 32'd0);
        tick();
        bus.req0 = 1'b0;
        #1;
        chk("rd_ram_en", 32'(bus.ram_en), 32'd1);
        chk("rd_ram_addr", 32'(bus.ram_addr), 32'h05);
        chk("rd_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rd_rvalid0_early", 32'(bus.rvalid0), 32'd0);
        tick();
        chk("rd_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("rd_rdata0", 32'(bus.rdata0), 32'h1234);
        chk("rd_rvalid1", 32'(bus.rvalid1), 32'd0);
        tick();
        chk("rd_rvalid0_once", 32'(bus.rvalid0), 32'd0);

        // Contention: both read continuously; grants alternate 0,1,0,1.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                bus.req0  = 1'b1;
                bus.req1  = 1'b1;
                bus.addr0 = 8'h20;
                bus.addr1 = 8'h21;
            end else begin
                idle_in();
            end
            #1;
            chk($sformatf("cont_gnt0_%0d", k), 32'(bus.gnt0), 32'((k < 4) && (k % 2 == 0)));
            chk($sformatf("cont_gnt1_%0d", k), 32'(bus.gnt1), 32'((k < 4) && (k % 2 == 1)));
            chk($sformatf("cont_ram_en_%0d", k), 32'(bus.ram_en), 32'((k >= 1) && (k <= 4)));
            chk($sformatf("cont_rvalid0_%0d", k), 32'(bus.rvalid0), 32'((k >= 2) && (k % 2 == 0)));
            chk($sformatf("cont_rvalid1_%0d", k), 32'(bus.rvalid1), 32'((k >= 3) && (k % 2 == 1)));
            if ((k >= 2) && (k % 2 == 0)) chk($sformatf("cont_rdata0_%0d", k), 32'(bus.rdata0), 32'hA0A0);
            if ((k >= 3) && (k % 2 == 1)) chk($sformatf("cont_rdata1_%0d", k), 32'(bus.rdata1), 32'hA1A1);
            tick();
        end
        chk("cont_ram_en_end", 32'(bus.ram_en), 32'd0);
        chk("cont_rvalid1_end", 32'(bus.rvalid1), 32'd0);

        // Lock: req0 held high throughout; req1 locks for 3 accesses, then
        // one unlocked access, then req0 gets the bus.
        do_reset();
        bus.req0  = 1'b1;
        bus.addr0 = 8'h20;
        #1;
        chk("lock_pre_gnt0", 32'(bus.gnt0), 32'd1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            bus.req1  = 1'b1;
            bus.addr1 = 8'h21;
            bus.lock1 = (i < 4);
            #1;
            chk($sformatf("lock_gnt1_%0d", i), 32'(bus.gnt1), 32'd1);
            chk($sformatf("lock_gnt0_%0d", i), 32'(bus.gnt0), 32'd0);
            tick();
        end
        bus.req1  = 1'b0;
        bus.lock1 = 1'b0;
        #1;
        chk("lock_after_gnt0", 32'(bus.gnt0), 32'd1);
        chk("lock_after_gnt1", 32'(bus.gnt1), 32'd0);
        tick();

        // Lock released when the owner drops its request.
        bus.lock0 = 1'b1;
        #1;
        chk("own0_gnt0", 32'(bus.gnt0), 32'd1);
        tick();
        bus.req0  = 1'b0;
        bus.lock0 = 1'b0;
        bus.req1  = 1'b1;
        #1;
        chk("own0_drop_gnt1", 32'(bus.gnt1), 32'd0);
        tick();
        #1;
        chk("own0_exit_gnt1", 32'(bus.gnt1), 32'd1);
        tick();
        idle_in();
        tick();
        tick();
        tick();

        // Write 0xBEEF to 0x10, then read it back.
        bus.req0   = 1'b1;
        bus.we0    = 1'b1;
        bus.addr0  = 8'h10;
        bus.wdata0 = 16'hBEEF;
        #1;
        chk("wr_gnt0", 32'(bus.gnt0), 32'd1);
        tick();
        bus.we0    = 1'b0;
        bus.wdata0 = '0;
        #1;
        chk("wr_ram_en", 32'(bus.ram_en), 32'd1);
        chk("wr_ram_we", 32'(bus.ram_we), 32'd1);
        chk("wr_ram_addr", 32'(bus.ram_addr), 32'h10);
        chk("wr_ram_wdata", 32'(bus.ram_wdata), 32'hBEEF);
        chk("wr_rd_gnt0", 32'(bus.gnt0), 32'd1);
        tick();
        idle_in();
        #1;
        chk("wr_no_rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("wr_rd_ram_we", 32'(bus.ram_we), 32'd0);
        chk("wr_rd_ram_en", 32'(bus.ram_en), 32'd1);
        tick();
        chk("wr_rd_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("wr_rd_rdata0", 32'(bus.rdata0), 32'hBEEF);
        tick();

        // Reset in the middle of a locked read.
        bus.req0  = 1'b1;
        bus.lock0 = 1'b1;
        bus.addr0 = 8'h05;
        #1;
        chk("mrst_gnt0", 32'(bus.gnt0), 32'd1);
        tick();
        rst      = 1'b0;
        bus.req1 = 1'b1;
        #1;
        chk("mrst_in_gnt0", 32'(bus.gnt0), 32'd0);
        chk("mrst_in_gnt1", 32'(bus.gnt1), 32'd0);
        chk("mrst_in_rvalid0", 32'(bus.rvalid0), 32'd0);
        tick();
        chk("mrst_t2_ram_en", 32'(bus.ram_en), 32'd0);
        chk("mrst_t2_rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("mrst_t2_rvalid1", 32'(bus.rvalid1), 32'd0);
        tick();
        chk("mrst_t3_ram_en", 32'(bus.ram_en), 32'd0);
        chk("mrst_t3_rvalid0", 32'(bus.rvalid0), 32'd0);
        rst       = 1'b1;
        bus.lock0 = 1'b0;
        bus.addr1 = 8'h21;
        #1;
        chk("mrst_rel_gnt0", 32'(bus.gnt0), 32'd1);
        chk("mrst_rel_gnt1", 32'(bus.gnt1), 32'd0);
        tick();
        chk("mrst_nolock_gnt1", 32'(bus.gnt1), 32'd1);
        chk("mrst_nolock_rvalid0", 32'(bus.rvalid0), 32'd0);
        idle_in();
        tick();
        tick();
        tick();

        // Idle.
        for (int c = 0; c < 10; c++) begin
            idle_in();
            #1;
            chk($sformatf("idle_ram_en_%0d", c), 32'(bus.ram_en), 32'd0);
            chk($sformatf("idle_gnt_%0d", c), 32'({bus.gnt1, bus.gnt0}), 32'd0);
            chk($sformatf("idle_rvalid_%0d", c), 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/single_port_ram_arb.md
SINGLE_PORT_RAM_ARB -- requirements
Module: single_port_ram_arb

Interface
REQ-001 Parameter: ADDR_W, default 8, RAM address width.
REQ-002 Parameter: DATA_W, default 16, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low (0 = reset), sampled on rising clk.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; valid with reqN.
REQ-007 lock0 / lock1  input  1  1 = keep ownership after this access; valid with reqN.
REQ-008 addr0 / addr1  input  ADDR_W  access address.
REQ-009 wdata0 / wdata1  input  DATA_W  write data.
REQ-010 gnt0 / gnt1  output  1  combinational; high in the cycle the request is accepted.
REQ-011 rvalid0 / rvalid1  output  1  read data return strobe, one cycle per accepted read.
REQ-012 rdata0 / rdata1  output  DATA_W  read data; valid only when rvalidN=1.
REQ-013 ram_en, ram_we  output  1  registered RAM enable and write enable.
REQ-014 ram_addr  output  ADDR_W  registered RAM address.
REQ-015 ram_wdata  output  DATA_W  registered RAM write data.
REQ-016 ram_rdata  input  DATA_W  RAM read data; valid one cycle after ram_en with ram_we=0.

Function
REQ-017 Handshake: reqN and its qualifiers are held stable until gntN=1; the access is accepted in that cycle.
REQ-018 At most one gnt per cycle; gntN is never asserted when reqN=0.
REQ-019 Throughput is one accepted access per cycle, with no idle cycle between back-to-back grants.
REQ-020 Arbitration states: RR (round-robin), OWN0 (locked to 0), OWN1 (locked to 1).
REQ-021 RR, single requester: grant it. RR, both requesting: grant the requester named by pointer prio; after any grant, prio = the other requester.
REQ-022 RR -> OWNn when reqn is granted with lockn=1.
REQ-023 OWNn: grant only requester n; the other requester is held off (gnt=0) regardless of prio.
REQ-024 OWNn -> RR when reqn is granted with lockn=0, or when reqn=0 in any OWNn cycle; prio = other requester on exit.
REQ-025 Command timing: grant in cycle T -> ram_en=1, ram_we=weN, ram_addr=addrN, ram_wdata=wdataN in cycle T+1; ram_en=0 in cycles with no grant.
REQ-026 Read return: a read granted in T -> rvalidN=1 in T+2 with rdataN=ram_rdata; tracked by a 2-stage valid/owner pipeline.
REQ-027 Writes produce no rvalid; returns to one requester never appear on the other.
REQ-028 rdataN is driven from ram_rdata and qualified only by rvalidN.
REQ-029 Data is passed through unchanged; there is no data arithmetic. The 2-stage valid/owner pipeline is the only tracking state.

Reset
REQ-030 rst=0 at a rising edge:
- state=RR, prio=requester 0
- ram_en=ram_we=0; ram_addr=ram_wdata=0
- both return-pipeline stages cleared; rvalid0=rvalid1=0
REQ-031 gnt0=gnt1=0 in every cycle with rst=0.
REQ-032 Reset mid-operation: all in-flight reads are discarded, with no rvalid in the cycles after reset is released. A lock is dropped.
REQ-033 The first cycle after reset release arbitrates normally.

Verification
REQ-034 Single read: req0=1, we0=0, addr0=0x05, RAM holds 0x1234 at 0x05 -> gnt0 in T; ram_en=1, ram_addr=0x05 in T+1; rvalid0=1, rdata0=0x1234 in T+2; rvalid1 stays 0.
REQ-035 Contention: req0 and req1 continuously asserted, reads, after reset -> grants 0,1,0,1 on consecutive cycles; ram_en=1 every cycle; returns alternate rvalid0/rvalid1 two cycles after each grant.
REQ-036 Lock: req1 with lock1=1 for 3 accesses, then lock1=0, with req0 held high -> gnt1 x4 consecutive, then gnt0 next cycle; gnt0=0 throughout the lock.
REQ-037 Write then read: req0 writes 0xBEEF to 0x10, then reads 0x10 -> ram_we=1 with ram_wdata=0xBEEF at T+1; no rvalid for the write; read returns 0xBEEF.
REQ-038 Reset mid-read: read granted in T, rst=0 in T+1 -> ram_en=0 and rvalid0=0 through T+3; state=RR, prio=0 after release.
REQ-039 Idle: req0=req1=0 for 10 cycles -> ram_en=0, gnt=0, rvalid=0 throughout.
